// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine for MULT, MULTU, DIV and DIVU.
// One shift/add or shift/subtract step per cycle on magnitudes, then a single sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic                 HiLoEn,
  output logic [2*WIDTH-1:0]   HiLoWrite,
  output logic                 DivByZero,
  output logic [1:0]           DbgState
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: Start is taken only on a rising edge where Busy=0 (IDLE); while
  // Busy=1 Start is ignored, nothing is queued. Done/HiLoEn pulse for one cycle
  // when HiLoWrite takes a new value; HiLoWrite then holds until the next Done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dbz_q, dbz_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   hilo_q, hilo_d;

  logic                 in_signed;
  logic                 in_div;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_w;
  logic [WIDTH-1:0]     rem_diff;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    hilo_d    = hilo_q;

    in_signed = ~Op[0];
    in_div    = Op[1];
    a_mag     = (in_signed && A[WIDTH-1]) ? -A : A;
    b_mag     = (in_signed && B[WIDTH-1]) ? -B : B;

    // Multiply: add multiplicand into the high half when the current LSB is set, then shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

    // Divide: {rem,quot} shifted left; rem_w is the widened shifted remainder.
    rem_w     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_w[WIDTH-1:0] - b_q;

    fix_hi    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_lo    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (Start) begin
          op_d      = Op;
          b_d       = b_mag;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          cnt_d     = CW'(WIDTH - 1);
          neg_res_d = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem_d = in_signed & A[WIDTH-1];
          dbz_d     = in_div && (B == '0);
          if (in_div && (B == '0)) begin
            // Divide by zero skips the datapath: Hi is the raw dividend, Lo all ones.
            acc_d   = {A, {WIDTH{1'b1}}};
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (op_q[1]) begin
          if (rem_w >= {1'b0, b_q}) begin
            acc_d = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_w[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (op_q[1]) begin
          acc_d = {fix_hi, fix_lo};
        end else if (neg_res_q) begin
          acc_d = -acc_q;
        end
        state_d = DONE;
      end

      DONE: begin
        done_d  = 1'b1;
        hilo_d  = acc_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      hilo_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      hilo_q    <= hilo_d;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign HiLoEn    = done_q;
  assign HiLoWrite = hilo_q;
  assign DivByZero = dbz_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed spec vectors plus randomized ops checked
// against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic [1:0]    Op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          Busy;
  logic          Done;
  logic          HiLoEn;
  logic [2*W-1:0] HiLoWrite;
  logic          DivByZero;
  logic [1:0]    DbgState;

  int n_checks = 0;
  int n_errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic           exp_dz_q[$];
  logic [2*W-1:0] last_hilo = '0;
  logic [2*W-1:0] mon_e;
  logic           mon_dz;

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .HiLoEn    (HiLoEn),
    .HiLoWrite (HiLoWrite),
    .DivByZero (DivByZero),
    .DbgState  (DbgState)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: {Hi,Lo} straight from signed/unsigned arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      2'd0: r = sa * sb;
      2'd1: r = {32'h0, a} * {32'h0, b};
      2'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // scoreboard: every cycle out of reset, Done/HiLoEn/HiLoWrite against the expected queue
  always @(negedge Clk) begin
    if (Rst === 1'b1) begin
      if (Done === 1'b1) begin
        check("done_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e  = exp_q.pop_front();
          mon_dz = exp_dz_q.pop_front();
          check("hilo_result", HiLoWrite, mon_e);
          check("dbz_at_done", DivByZero, mon_dz);
          check("hiloen_pulse", HiLoEn, 1);
          last_hilo = mon_e;
        end
      end else begin
        check("hiloen_idle", HiLoEn, 0);
        check("hilo_hold", HiLoWrite, last_hilo);
      end
    end
  end

  // driver: call at a negedge with the DUT idle; returns at the negedge where Done is seen
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
    int  lat;
    bit  seen;
    logic dz;
    dz  = op[1] && (b == 0);
    lat = dz ? 2 : W + 3;
    Start = 1'b1; Op = op; A = a; B = b;
    exp_q.push_back(model(op, a, b));
    exp_dz_q.push_back(dz);
    @(posedge Clk);
    #1;
    Start = 1'b0; Op = 2'($urandom); A = $urandom; B = $urandom;
    seen = 1'b0;
    for (int k = 1; k <= lat + 3 && !seen; k++) begin
      @(negedge Clk);
      Start = (k == poke);
      if (k == poke) begin
        A = $urandom; B = $urandom; Op = 2'($urandom);
      end
      check("busy", Busy, k < lat);
      if (k == 1) check("dbz_after_start", DivByZero, dz);
      if (Done === 1'b1) begin
        seen = 1'b1;
        check("latency", k, lat);
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    Start = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'($urandom_range(0, 300));
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    Rst = 1'b0; Start = 1'b0; Op = 2'd0; A = '0; B = '0;

    // model pinned by hand-computed values
    check("model_mult",  model(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
    check("model_multu", model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("model_div",   model(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("model_divu",  model(2'd3, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
    check("model_dbz",   model(2'd3, 32'h1234, 32'd0), 64'h0000_1234_FFFF_FFFF);
    check("model_ovf",   model(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

    repeat (3) @(negedge Clk);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_hiloen", HiLoEn, 0);
    check("reset_hilo", HiLoWrite, 0);
    check("reset_dbz", DivByZero, 0);
    check("reset_state", DbgState, 0);
    Rst = 1'b1;
    @(negedge Clk);

    // directed vectors, back-to-back
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'd3, 32'd100, 32'd7, 0);
    run_op(2'd3, 32'h1234, 32'd0, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'd17, 32'd0, 0);
    run_op(2'd0, 32'd6, 32'd7, 5);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 20);

    // reset during a MULT
    Start = 1'b1; Op = 2'd0; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_hilo", HiLoWrite, 0);
    check("abort_done", Done, 0);
    check("abort_state", DbgState, 0);
    exp_q.delete();
    exp_dz_q.delete();
    last_hilo = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    repeat (40) @(negedge Clk);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // randomized ops, some with mid-operation Start pokes
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      int          r_poke;
      r_op   = 2'($urandom_range(0, 3));
      r_a    = pick_operand();
      r_b    = pick_operand();
      r_poke = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      run_op(r_op, r_a, r_b, r_poke);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge Clk);
    end

    repeat (3) @(negedge Clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
